// File: rtl/xor_nand_gate_pkg.sv
// Shared constants for the NAND-built XOR block.
//   WIDTH_DEF   : default operand width
//   CNT_W_DEF   : default width of the capture counter
//   CNT_SAT_DEF : saturation value of a CNT_W_DEF-bit counter
//   sat_value() : all-ones value for a counter of a given width (up to 32 bits)
package xor_nand_gate_pkg;

  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 16;

  function automatic logic [31:0] sat_value(input int w);
    // 1 << 32 wraps to 0, so a 32-bit counter still yields all ones
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam logic [31:0] CNT_SAT_DEF = sat_value(CNT_W_DEF);

endpackage

// File: rtl/xor_nand_gate_cell.sv
// xor_nand_cell: one-bit XOR built from four 2-input NAND gates.
//   a, b : operand bits
//   y    : a ^ b
module xor_nand_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  logic n1;
  logic n2;
  logic n3;

  assign n1 = ~(a & b);
  assign n2 = ~(a & n1);
  assign n3 = ~(b & n1);
  assign y  = ~(n2 & n3);

endmodule

// File: rtl/xor_nand_gate.sv
// xor_nand_gate: WIDTH-bit NAND-built XOR with a registered copy, a one-cycle
// capture strobe and a saturating count of nonzero captures.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (registers, counter, flag)
//   a, b     : operands
//   en       : capture enable for y_q / y_valid / ones_cnt
//   cnt_clr  : synchronous clear of ones_cnt and cnt_sat (wins over increment)
//   y        : combinational a ^ b
//   y_q      : y captured on the last enabled edge
//   y_valid  : high for the cycle following each capture
//   ones_cnt : saturating count of captures where y had any bit set
//   cnt_sat  : sticky flag, set when ones_cnt reaches its maximum
module xor_nand_gate
  import xor_nand_gate_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_valid,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             cnt_sat
);

  localparam logic [31:0]      CNT_MAX_W = sat_value(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX_W[CNT_W-1:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = sat_inc(ones_cnt);

  // Stage p0: combinational XOR, independent of clock and reset
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    xor_nand_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .y (y[i])
    );
  end

  // Stage p1: captured result and its strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= en;
      if (en) begin
        y_q <= y;
      end
    end
  end

  // Stage p1: counter; clear takes priority over a same-edge increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else if (cnt_clr) begin
      ones_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else if (en && (|y)) begin
      ones_cnt <= cnt_inc;
      if (cnt_inc == CNT_MAX) begin
        cnt_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xor_nand_gate.sv
module tb_xor_nand_gate;

  logic        clk;
  logic        clk_on;
  logic        rst_n;
  logic        en;
  logic        cnt_clr;

  logic        a1, b1, y1, yq1, yv1, sat1;
  logic [3:0]  cnt1;

  logic [7:0]  a8, b8, y8, yq8;
  logic        yv8, sat8;
  logic [15:0] cnt8;

  int checks;
  int failures;

  typedef struct packed {
    logic       yq;
    logic [3:0] cnt;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];

  // reference model state for the 1-bit, 4-bit-counter instance
  logic       m_yq;
  logic [3:0] m_cnt;
  logic       m_sat;

  xor_nand_gate #(.WIDTH(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .en(en), .cnt_clr(cnt_clr),
    .y(y1), .y_q(yq1), .y_valid(yv1), .ones_cnt(cnt1), .cnt_sat(sat1)
  );

  xor_nand_gate #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .en(en), .cnt_clr(cnt_clr),
    .y(y8), .y_q(yq8), .y_valid(yv8), .ones_cnt(cnt8), .cnt_sat(sat8)
  );

  initial begin
    clk = 1'b0;
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe from u1 must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && yv1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid: got y_valid=1 expected no capture at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_y_q", 32'(yq1), 32'(e.yq));
        chk("sb_ones_cnt", 32'(cnt1), 32'(e.cnt));
        chk("sb_cnt_sat", 32'(sat1), 32'(e.sat));
      end
    end
  end

  // Apply one cycle of stimulus (called just after a rising edge) with the
  // hand-computed XOR result exp_y; queue the expected capture if enabled.
  task automatic step(input logic va, input logic vb, input logic ven,
                      input logic vclr, input logic exp_y);
    a1 = va; b1 = vb; en = ven; cnt_clr = vclr;
    #1;
    chk("comb_y", 32'(y1), 32'(exp_y));
    if (vclr) begin
      m_cnt = 4'd0;
      m_sat = 1'b0;
    end else if (ven && exp_y) begin
      if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      if (m_cnt == 4'hF) m_sat = 1'b1;
    end
    if (ven) begin
      m_yq = exp_y;
      exp_q.push_back('{yq: m_yq, cnt: m_cnt, sat: m_sat});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    clk_on = 1'b0;
    rst_n = 1'b0; en = 1'b0; cnt_clr = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    m_yq = 1'b0; m_cnt = 4'd0; m_sat = 1'b0;

    // reset state, no clock running
    #1;
    chk("rst_y_q", 32'(yq1), 32'd0);
    chk("rst_y_valid", 32'(yv1), 32'd0);
    chk("rst_ones_cnt", 32'(cnt1), 32'd0);
    chk("rst_cnt_sat", 32'(sat1), 32'd0);
    chk("rst_y_q8", 32'(yq8), 32'd0);

    // truth table with clock stopped (and reset held)
    a1 = 0; b1 = 0; #10; chk("tt_00", 32'(y1), 32'd0);
    a1 = 0; b1 = 1; #10; chk("tt_01", 32'(y1), 32'd1);
    a1 = 1; b1 = 0; #10; chk("tt_10", 32'(y1), 32'd1);
    a1 = 1; b1 = 1; #10; chk("tt_11", 32'(y1), 32'd0);
    a8 = 8'hA5; b8 = 8'h0F; #10; chk("y8_comb", 32'(y8), 32'h0000_00AA);

    // start clock and release reset between edges
    clk_on = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // three captures of a=1,b=0 then idle
    step(1, 0, 1, 0, 1);
    chk("y_q8_capture", 32'(yq8), 32'h0000_00AA);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("hold_y_q", 32'(yq1), 32'd1);
    chk("hold_ones_cnt", 32'(cnt1), 32'd3);
    chk("idle_valid", 32'(yv1), 32'd0);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y_q", 32'(yq1), 32'd0);
    chk("arst_y_valid", 32'(yv1), 32'd0);
    chk("arst_ones_cnt", 32'(cnt1), 32'd0);
    chk("arst_cnt_sat", 32'(sat1), 32'd0);
    a1 = 1; b1 = 1; #1; chk("arst_y_11", 32'(y1), 32'd0);
    a1 = 0; b1 = 1; #1; chk("arst_y_01", 32'(y1), 32'd1);
    // an enabled edge while reset is held must capture nothing
    en = 1'b1; a1 = 1; b1 = 0;
    @(posedge clk); #1;
    chk("arst_no_capture", 32'(yq1), 32'd0);
    chk("arst_no_count", 32'(cnt1), 32'd0);
    en = 1'b0;
    rst_n = 1'b1;
    m_yq = 1'b0; m_cnt = 4'd0; m_sat = 1'b0;
    @(posedge clk); #1;

    // first enabled edge after reset captures; then saturate the 4-bit counter
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("sat_ones_cnt", 32'(cnt1), 32'd15);
    chk("sat_flag", 32'(sat1), 32'd1);

    // clear with simultaneous enabled nonzero capture
    step(1, 0, 1, 1, 1);
    step(0, 1, 0, 0, 1);
    chk("clr_ones_cnt", 32'(cnt1), 32'd0);
    chk("clr_cnt_sat", 32'(sat1), 32'd0);
    chk("clr_y_q", 32'(yq1), 32'd1);

    // zero result does not count
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("zero_not_counted", 32'(cnt1), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_nand_gate.md
XOR_NAND_GATE -- requirements
Module: xor_nand_gate

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the bit width of a, b, y, y_q.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of ones_cnt.
REQ-003 clk, input, 1, SHALL be the single clock, rising-edge active.
REQ-004 rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 a, input, WIDTH, SHALL be operand A.
REQ-006 b, input, WIDTH, SHALL be operand B.
REQ-007 en, input, 1, SHALL be the capture enable for the registered path.
REQ-008 cnt_clr, input, 1, SHALL be the synchronous clear for ones_cnt and cnt_sat.
REQ-009 y, output, WIDTH, SHALL be the combinational XOR of a and b.
REQ-010 y_q, output, WIDTH, SHALL be the registered y.
REQ-011 y_valid, output, 1, SHALL be high for one cycle after each capture.
REQ-012 ones_cnt, output, CNT_W, SHALL be the saturating count of captures with y nonzero.
REQ-013 cnt_sat, output, 1, SHALL be the sticky flag set when ones_cnt reaches its maximum.

Function
REQ-014 Per bit i, y[i] SHALL equal a[i] XOR b[i], built only from 2-input NANDs:
- n1 = NAND(a,b)
- n2 = NAND(a,n1)
- n3 = NAND(b,n1)
- y = NAND(n2,n3)
REQ-015 y SHALL be purely combinational, with no clock or reset dependency, and valid within the same time step as any a/b change.
REQ-016 Truth table per bit SHALL be: 00->0, 01->1, 10->1, 11->0.
REQ-017 On a rising clk with en=1, y_q SHALL load y and y_valid SHALL be 1 in the following cycle.
REQ-018 On a rising clk with en=0, y_q SHALL hold its value and y_valid SHALL be 0.
REQ-019 Capture latency SHALL be 1 cycle: y_q at cycle n+1 equals y sampled at edge n.
REQ-020 On a rising clk with en=1 and y nonzero (any bit set), ones_cnt SHALL increment by 1.
REQ-021 ones_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-022 cnt_sat SHALL set on the edge where ones_cnt becomes 2^CNT_W-1, and SHALL stay set until cleared.
REQ-023 cnt_clr=1 SHALL zero ones_cnt and cnt_sat on the next edge.
REQ-024 cnt_clr SHALL take priority over a simultaneous increment.
REQ-025 cnt_clr SHALL NOT affect y_q or y_valid.

Reset
REQ-026 While rst_n=0, y_q, y_valid, ones_cnt and cnt_sat SHALL be 0 immediately, without waiting for clk.
REQ-027 y SHALL continue to track a and b during reset.
REQ-028 Reset asserted mid-operation SHALL discard any capture on that edge.
REQ-029 After rst_n deassertion, the first capture SHALL occur on the first rising clk with en=1.

Structure
REQ-030 A shared package SHALL hold:
- default WIDTH and CNT_W constants
- the saturation value constant derived from CNT_W
REQ-031 One sub-module, xor_nand_cell, SHALL implement the 1-bit four-NAND XOR.
REQ-032 xor_nand_cell SHALL be instantiated WIDTH times via generate.
REQ-033 Registers, counter and flags SHALL reside in xor_nand_gate.

Verification
REQ-034 With WIDTH=1 and no clock running, drive a/b = 00, 01, 10, 11, each held 10 time units -> y = 0, 1, 1, 0.
REQ-035 Hold rst_n=0 mid-run with y_q=1 -> y_q, y_valid, ones_cnt, cnt_sat = 0 at once, while y still follows a^b.
REQ-036 Drive a=1, b=0, en=1 for 3 cycles, then en=0 -> y_q=1, y_valid high for exactly 3 cycles, ones_cnt=3.
REQ-037 With CNT_W=4, hold y=1, en=1 for 20 cycles -> ones_cnt stops at 15 and cnt_sat=1 from the 15th capture onward.
REQ-038 Assert cnt_clr and en with y=1 on the same edge -> ones_cnt=0, cnt_sat=0, y_q=1.
REQ-039 With WIDTH=8, a=8'hA5, b=8'h0F -> y=8'hAA, and y_q=8'hAA one cycle after a capture with en=1.
